// File: rtl/riscv_pkg.sv
// Shared RISC-V decode constants and field helpers.
// Opcodes, register-index width and an ID field extractor.
package riscv_pkg;

  localparam int REG_W = 5;

  typedef logic [REG_W-1:0] reg_idx_t;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef struct packed {
    reg_idx_t   rs2;
    reg_idx_t   rs1;
    reg_idx_t   rd;
    logic [6:0] opcode;
  } id_fields_t;

  function automatic id_fields_t decode(
    input logic [31:0] ins
  );
    id_fields_t f;
    f.rs2    = ins[24:20];
    f.rs1    = ins[19:15];
    f.rd     = ins[11:7];
    f.opcode = ins[6:0];
    return f;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-stage / write-back bundle for the load hazard scoreboard.
// master: pipeline side (drives ID + WB); slave: scoreboard.
interface hazard_scoreboard_if;
  import riscv_pkg::*;

  logic [31:0] instruction_ID;
  logic        issue_valid;
  logic        flush_ID;
  logic        ld_done;
  reg_idx_t    ld_rd;
  logic        stall_ID;
  logic        busy;
  logic [31:0] stall_count;

  modport master (
    output instruction_ID,
    output issue_valid,
    output flush_ID,
    output ld_done,
    output ld_rd,
    input  stall_ID,
    input  busy,
    input  stall_count
  );

  modport slave (
    input  instruction_ID,
    input  issue_valid,
    input  flush_ID,
    input  ld_done,
    input  ld_rd,
    output stall_ID,
    output busy,
    output stall_count
  );

endinterface

// File: rtl/sb_counter.sv
// Per-register in-flight load counter, saturating both ways.
// Ports: clk, arst, i_inc, i_dec -> o_nz (count>0), o_max (full).
module sb_counter #(
  parameter int CNT_W = 2
) (
  input  logic clk,
  input  logic arst,
  input  logic i_inc,
  input  logic i_dec,
  output logic o_nz,
  output logic o_max
);

  logic [CNT_W-1:0] r_cnt;
  logic             w_inc;
  logic             w_dec;

  assign o_nz  = |r_cnt;
  assign o_max = &r_cnt;

  // Clamp at both ends; a matched inc/dec pair cancels.
  assign w_inc = i_inc & ~o_max;
  assign w_dec = i_dec & o_nz;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_cnt <= '0;
    end else if (w_inc & ~w_dec) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else if (w_dec & ~w_inc) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Load-use hazard scoreboard: stalls ID on pending load targets.
// Ports: clk, arst, sb (slave: ID instr, WB ld_done -> stall/busy/count).
module hazard_scoreboard
  import riscv_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic                clk,
  input  logic                arst,
  hazard_scoreboard_if.slave  sb
);

  id_fields_t  w_id;
  logic        w_use_rs1;
  logic        w_use_rs2;
  logic        w_is_load;
  logic [31:0] w_nz;
  logic [31:0] w_max;
  logic        w_active;
  logic        w_stall;
  logic        w_issue;
  logic        w_ld_inc;
  logic [31:0] r_stall_cnt;

  assign w_id = decode(sb.instruction_ID);

  always_comb begin
    w_use_rs1 = 1'b1;
    w_use_rs2 = 1'b0;
    w_is_load = 1'b0;
    case (w_id.opcode)
      OPC_LUI,
      OPC_AUIPC,
      OPC_JAL:    w_use_rs1 = 1'b0;
      OPC_OP,
      OPC_STORE,
      OPC_BRANCH: w_use_rs2 = 1'b1;
      OPC_LOAD:   w_is_load = 1'b1;
      default:    ;
    endcase
  end

  // x0 has no counter; tying its flags low removes it from every check.
  assign w_nz[0]  = 1'b0;
  assign w_max[0] = 1'b0;

  assign w_active = sb.issue_valid & ~sb.flush_ID;
  assign w_stall  = w_active & (
                      (w_use_rs1 & w_nz[w_id.rs1]) |
                      (w_use_rs2 & w_nz[w_id.rs2]) |
                      (w_is_load & w_max[w_id.rd]));
  assign w_issue  = w_active & ~w_stall;
  assign w_ld_inc = w_issue & w_is_load;

  for (genvar g = 1; g < 32; g++) begin : g_cnt
    logic w_inc;
    logic w_dec;

    assign w_inc = w_ld_inc & (w_id.rd == REG_W'(g));
    assign w_dec = sb.ld_done & (sb.ld_rd == REG_W'(g));

    sb_counter #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk   (clk),
      .arst  (arst),
      .i_inc (w_inc),
      .i_dec (w_dec),
      .o_nz  (w_nz[g]),
      .o_max (w_max[g])
    );
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_stall_cnt <= '0;
    end else if (w_stall && r_stall_cnt != 32'hFFFF_FFFF) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign sb.stall_ID    = w_stall;
  assign sb.busy        = |w_nz;
  assign sb.stall_count = r_stall_cnt;

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter: CNT_W, default 2; width of each per-register in-flight load counter (maximum count 2^CNT_W-1).
REQ-002 Port: clk  input  1  pipeline clock; all state updates on its rising edge.
REQ-003 Port: arst  input  1  reset, asynchronous, active-high.
REQ-004 Port: instruction_ID  input  32  instruction in ID; rs1=[19:15], rs2=[24:20], rd=[11:7], opcode=[6:0].
REQ-005 Port: issue_valid  input  1  ID instruction is valid and advances to EX this cycle unless stalled.
REQ-006 Port: flush_ID  input  1  ID instruction is squashed this cycle (branch taken or exception).
REQ-007 Port: ld_done  input  1  a load result is written back this cycle.
REQ-008 Port: ld_rd  input  5  destination register of the load completing on ld_done.
REQ-009 Port: stall_ID  output  1  hold PC and IF/ID and insert a bubble into EX.
REQ-010 Port: busy  output  1  at least one load is in flight.
REQ-011 Port: stall_count  output  32  count of cycles with stall_ID asserted.

Function
REQ-012 The block SHALL hold one CNT_W-bit counter per register x1..x31; x0 has no counter and never hazards.
REQ-013 rs1 is used for every opcode except LUI 0110111, AUIPC 0010111 and JAL 1101111; rs2 is used only for 0110011, 0100011 and 1100011.
REQ-014 A load is an instruction with opcode 0000011.
REQ-015 stall_ID SHALL be combinational and asserted when issue_valid=1, flush_ID=0, and either a used source register (nonzero) has counter>0, or the instruction is a load with rd!=0 whose counter is at its maximum.
REQ-016 Issue SHALL occur when issue_valid=1, flush_ID=0 and stall_ID=0; an issued load with rd!=0 increments counter[rd] on the next edge.
REQ-017 ld_done=1 with ld_rd!=0 SHALL decrement counter[ld_rd] on the next edge; ld_done for a zero counter or for ld_rd=0 is ignored and leaves all state unchanged.
REQ-018 An issue increment and an ld_done decrement to the same register in the same cycle SHALL leave that counter unchanged.
REQ-019 Counters SHALL never wrap: at maximum, REQ-015 blocks further increments; at zero, REQ-017 blocks decrements.
REQ-020 ld_done SHALL NOT clear a stall in the same cycle; a dependent instruction issues one cycle after the completing write-back, when operands are read via the WB forwarding path.
REQ-021 A load issued while ld_done completes a different register SHALL update both counters independently in the same cycle.
REQ-022 busy SHALL be registered-state derived: 1 when any counter is nonzero.
REQ-023 stall_count SHALL increment by 1 each cycle that stall_ID=1 and saturate at 32'hFFFFFFFF.
REQ-024 flush_ID=1 SHALL suppress both stall_ID and issue for that cycle, regardless of the other inputs.

Reset
REQ-025 While arst=1: all counters are 0, stall_count=0, busy=0, and stall_ID=0 because no counter is set.
REQ-026 Reset asserted mid-operation SHALL discard all in-flight load tracking immediately; ld_done arriving after reset deassertion for a pre-reset load is ignored under REQ-017.

Structure
REQ-027 The opcode constants (LOAD, LUI, AUIPC, JAL, OP, STORE, BRANCH) and the register-index width SHALL live in the shared riscv_pkg package.
REQ-028 The per-register counter with its increment, decrement and saturation logic SHALL be a sub-module sb_counter, instantiated 31 times via generate.

Verification
REQ-029 Load-use: issue lw x5 (0x0002A283-style encoding, rd=5), then add x6,x5,x1 in ID -> stall_ID=1 until ld_done with ld_rd=5; the add issues on the following cycle; stall_count equals the number of stalled cycles.
REQ-030 No false hazard: after issuing a load to rd=0, then lui x7 / jal with rs fields matching pending registers -> stall_ID=0 and busy=0.
REQ-031 Saturation: with CNT_W=2, issue 3 loads to x9 without ld_done, then a 4th load to x9 -> stall_ID=1 and counter[x9]=3 is held; a single ld_done(9) unblocks the 4th load.
REQ-032 Simultaneous events: issue a load to x3 in the same cycle as ld_done(3) with counter=1 -> counter stays 1 and busy=1; issue a load to x4 with ld_done(3) -> counters x3=0, x4=1.
REQ-033 Flush and reset: a dependent stalled instruction with flush_ID=1 -> stall_ID=0 and no increment; assert arst mid-stall -> stall_ID=0, busy=0 and stall_count=0 immediately.
